// File: rtl/hdmi_text_grid_pkg.sv
// Shared constants for the HDMI text grid: flag values, default glyph/grid
// geometry and the sync-state encoding.
package hdmi_text_grid_pkg;
  localparam bit YES = 1'b1;
  localparam bit NO  = 1'b0;

  localparam int DEF_GLYPH_W = 10;
  localparam int DEF_GLYPH_H = 20;
  localparam int DEF_COLS    = 80;
  localparam int DEF_ROWS    = 24;

  typedef enum logic {
    UNSYNCED = 1'b0,
    SYNCED   = 1'b1
  } sync_state_e;
endpackage

// File: rtl/hdmi_text_grid_if.sv
// Timing-strobe in / grid-coordinate out bundle for hdmi_text_grid.
// fine_row only exists when HDMI_TEXT_FINE_SCROLL_EN is defined.
import hdmi_text_grid_pkg::*;

interface hdmi_text_grid_if #(
  parameter int GLYPH_W = DEF_GLYPH_W,
  parameter int GLYPH_H = DEF_GLYPH_H,
  parameter int COLS    = DEF_COLS,
  parameter int ROWS    = DEF_ROWS
);
  localparam int CB = $clog2(COLS);
  localparam int RB = $clog2(ROWS);
  localparam int WB = $clog2(GLYPH_W);
  localparam int HB = $clog2(GLYPH_H);

  logic          in_active;
  logic          in_h_sync;
  logic          in_v_sync;
  logic          in_h_start;
  logic          in_v_start;
  logic [RB-1:0] top_row;
`ifdef HDMI_TEXT_FINE_SCROLL_EN
  logic [HB-1:0] fine_row;
`endif

  logic          out_active;
  logic          out_h_sync;
  logic          out_v_sync;
  logic [CB-1:0] out_col;
  logic [WB-1:0] out_col_pixel;
  logic          out_col_start;
  logic [RB-1:0] out_row;
  logic [HB-1:0] out_row_pixel;
  logic          out_row_start;
  logic          out_frame_start;
  logic          out_in_text;

  // timing generator side
  modport master (
`ifdef HDMI_TEXT_FINE_SCROLL_EN
    output fine_row,
`endif
    output in_active, in_h_sync, in_v_sync, in_h_start, in_v_start, top_row,
    input  out_active, out_h_sync, out_v_sync, out_col, out_col_pixel, out_col_start,
    input  out_row, out_row_pixel, out_row_start, out_frame_start, out_in_text
  );

  // grid mapper side
  modport slave (
`ifdef HDMI_TEXT_FINE_SCROLL_EN
    input  fine_row,
`endif
    input  in_active, in_h_sync, in_v_sync, in_h_start, in_v_start, top_row,
    output out_active, out_h_sync, out_v_sync, out_col, out_col_pixel, out_col_start,
    output out_row, out_row_pixel, out_row_start, out_frame_start, out_in_text
  );
endinterface

// File: rtl/hdmi_text_wrap_counter.sv
// Modulo-(MAX+1) counter with load/clear and a combinational wrap carry.
// Priority: reset > load > clear > inc.
module hdmi_text_wrap_counter #(
  parameter int MAX = 9,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap
);
  logic [W-1:0] count_q, count_d;

  assign wrap  = inc & (count_q == W'(MAX));
  assign count = count_q;

  // next count: load, clear, or step with wrap back to zero
  always_comb begin
    count_d = count_q;
    if (load)      count_d = load_val;
    else if (clear) count_d = '0;
    else if (inc)   count_d = wrap ? '0 : count_q + W'(1);
  end

  // count register
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end
endmodule

// File: rtl/hdmi_text_grid.sv
// HDMI timing strobes -> character-cell coordinates, one clock of latency.
// Optional fine (sub-glyph) vertical scroll: define HDMI_TEXT_FINE_SCROLL_EN.
import hdmi_text_grid_pkg::*;

module hdmi_text_grid #(
  parameter int GLYPH_W = DEF_GLYPH_W,
  parameter int GLYPH_H = DEF_GLYPH_H,
  parameter int COLS    = DEF_COLS,
  parameter int ROWS    = DEF_ROWS
) (
  input logic             clk,
  input logic             reset,
  hdmi_text_grid_if.slave bus
);
  localparam int CB     = $clog2(COLS);
  localparam int RB     = $clog2(ROWS);
  localparam int WB     = $clog2(GLYPH_W);
  localparam int HB     = $clog2(GLYPH_H);
  localparam int NLINES = ROWS * GLYPH_H;
  localparam int SB     = $clog2(NLINES + 1);
  localparam logic [CB:0] COLS_L = (CB + 1)'(COLS);
  localparam logic [RB:0] ROWS_L = (RB + 1)'(ROWS);
  localparam logic [HB:0] GH_L   = (HB + 1)'(GLYPH_H);

  sync_state_e   state_q, state_d;
  logic [CB-1:0] col_q, col_d;
  logic [SB-1:0] scan_q, scan_d;
  logic          active_q, hs_q, vs_q;
  logic          col_start_q, col_start_d;
  logic          row_start_q, row_start_d;
  logic          frame_start_q, frame_start_d;
  logic          in_text_q, in_text_d;

  logic          act, hst, fs, row_adv;
  logic          cp_wrap, rp_wrap, row_wrap_unused;
  logic [WB-1:0] col_pixel;
  logic [HB-1:0] row_pixel, fine_eff;
  logic [RB-1:0] row, top_eff;

  // everything but in_active is qualified by active video
  assign act     = bus.in_active;
  assign hst     = act & bus.in_h_start;
  assign fs      = hst & bus.in_v_start;
  assign row_adv = hst & ~bus.in_v_start & (state_q == SYNCED);

  // out-of-range scroll offsets fall back to zero
  always_comb begin
    top_eff  = ({1'b0, bus.top_row} >= ROWS_L) ? '0 : bus.top_row;
    fine_eff = '0;
`ifdef HDMI_TEXT_FINE_SCROLL_EN
    if ({1'b0, bus.fine_row} < GH_L) fine_eff = bus.fine_row;
`endif
  end

  hdmi_text_wrap_counter #(.MAX(GLYPH_W - 1), .W(WB)) u_col_pixel (
    .clk(clk), .reset(reset), .load(1'b0), .load_val('0),
    .clear(~act | hst), .inc(act & ~hst), .count(col_pixel), .wrap(cp_wrap)
  );

  hdmi_text_wrap_counter #(.MAX(GLYPH_H - 1), .W(HB)) u_row_pixel (
    .clk(clk), .reset(reset), .load(fs), .load_val(fine_eff),
    .clear(1'b0), .inc(row_adv), .count(row_pixel), .wrap(rp_wrap)
  );

  hdmi_text_wrap_counter #(.MAX(ROWS - 1), .W(RB)) u_row (
    .clk(clk), .reset(reset), .load(fs), .load_val(top_eff),
    .clear(1'b0), .inc(rp_wrap), .count(row), .wrap(row_wrap_unused)
  );

  // sync FSM, column/scanline counters and flag generation
  always_comb begin
    state_d = state_q;
    if (fs) state_d = SYNCED;

    col_d = col_q;
    if (!act || hst)             col_d = '0;
    else if (cp_wrap && col_q != '1) col_d = col_q + CB'(1);

    scan_d = scan_q;
    if (fs)                           scan_d = '0;
    else if (row_adv && scan_q != '1) scan_d = scan_q + SB'(1);

    col_start_d   = act & (hst | cp_wrap);
    frame_start_d = fs;
    row_start_d   = fs ? (fine_eff == '0) : (row_adv & rp_wrap);
    in_text_d     = (state_d == SYNCED) & act & ({1'b0, col_d} < COLS_L)
                  & (scan_d < SB'(NLINES));
  end

  // output and state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= UNSYNCED;
      col_q         <= '0;
      scan_q        <= '0;
      active_q      <= 1'b0;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      col_start_q   <= 1'b0;
      row_start_q   <= 1'b0;
      frame_start_q <= 1'b0;
      in_text_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      scan_q        <= scan_d;
      active_q      <= act;
      hs_q          <= bus.in_h_sync;
      vs_q          <= bus.in_v_sync;
      col_start_q   <= col_start_d;
      row_start_q   <= row_start_d;
      frame_start_q <= frame_start_d;
      in_text_q     <= in_text_d;
    end
  end

  assign bus.out_active      = active_q;
  assign bus.out_h_sync      = hs_q;
  assign bus.out_v_sync      = vs_q;
  assign bus.out_col         = col_q;
  assign bus.out_col_pixel   = col_pixel;
  assign bus.out_col_start   = col_start_q;
  assign bus.out_row         = row;
  assign bus.out_row_pixel   = row_pixel;
  assign bus.out_row_start   = row_start_q;
  assign bus.out_frame_start = frame_start_q;
  assign bus.out_in_text     = in_text_q;
endmodule

// File: tb/tb_hdmi_text_grid.sv
// Bench for hdmi_text_grid: small geometry so whole frames stay short.
// Reference model tracks pixel x / line y since frame start and derives
// every output arithmetically.
module tb_hdmi_text_grid;
  localparam int GW = 4, GH = 3, COLS = 10, ROWS = 24;
  localparam int CB = $clog2(COLS), RB = $clog2(ROWS), HB = $clog2(GH);
  localparam int COL_SAT = (1 << CB) - 1;
  localparam int W = 44;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hdmi_text_grid_if #(.GLYPH_W(GW), .GLYPH_H(GH), .COLS(COLS), .ROWS(ROWS)) bus();
  hdmi_text_grid #(.GLYPH_W(GW), .GLYPH_H(GH), .COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int total = 0, bad = 0;
  int fine_v = 0;

  // model state
  int mx = 0, my = 0, mtop = 0, mfine = 0;
  bit msync = 0;
  int e_act, e_hs, e_vs, e_col, e_cp, e_cs, e_row, e_rp, e_rs, e_fs, e_it;

  typedef struct {
    bit a, hs, vs, hst, vst;
    int top;
    int col, cp, cs, row, rp, rs, fs, it;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model(input bit a, hs, vs, hst, vst, input int top, input int fine);
    int f, s;
    f = fine;
    if (reset) begin
      mx = 0; msync = 0; my = 0; mtop = 0; mfine = 0;
      {e_act, e_hs, e_vs, e_col, e_cp, e_cs, e_row, e_rp, e_rs, e_fs, e_it} = '0;
      return;
    end
    e_act = a; e_hs = hs; e_vs = vs;
    e_rs = 0; e_fs = 0;
    if (!a) mx = 0;
    else begin
      mx = hst ? 0 : mx + 1;
      if (hst && vst) begin
        msync = 1; my = 0;
        mtop  = (top >= ROWS) ? 0 : top;
`ifdef HDMI_TEXT_FINE_SCROLL_EN
        mfine = (f >= GH) ? 0 : f;
`else
        mfine = 0;
`endif
        e_fs = 1;
        e_rs = (mfine == 0);
      end else if (hst && msync) begin
        my++;
        e_rs = ((my + mfine) % GH == 0);
      end
    end
    s     = my + mfine;
    e_col = (mx / GW > COL_SAT) ? COL_SAT : mx / GW;
    e_cp  = mx % GW;
    e_cs  = a && (mx % GW == 0);
    e_row = msync ? (mtop + s / GH) % ROWS : 0;
    e_rp  = msync ? s % GH : 0;
    e_it  = msync && a && (mx / GW < COLS) && (my < ROWS * GH);
  endtask

  task automatic cyc(input bit a, hs, vs, hst, vst, input int top, input int fine);
    bus.in_active  = a;
    bus.in_h_sync  = hs;
    bus.in_v_sync  = vs;
    bus.in_h_start = hst;
    bus.in_v_start = vst;
    bus.top_row    = top[RB-1:0];
`ifdef HDMI_TEXT_FINE_SCROLL_EN
    bus.fine_row   = fine[HB-1:0];
`endif
    @(posedge clk); #1;
    model(a, hs, vs, hst, vst, top % (1 << RB), fine % (1 << HB));
    chk("active",      int'(bus.out_active),      e_act);
    chk("h_sync",      int'(bus.out_h_sync),      e_hs);
    chk("v_sync",      int'(bus.out_v_sync),      e_vs);
    chk("col",         int'(bus.out_col),         e_col);
    chk("col_pixel",   int'(bus.out_col_pixel),   e_cp);
    chk("col_start",   int'(bus.out_col_start),   e_cs);
    chk("row",         int'(bus.out_row),         e_row);
    chk("row_pixel",   int'(bus.out_row_pixel),   e_rp);
    chk("row_start",   int'(bus.out_row_start),   e_rs);
    chk("frame_start", int'(bus.out_frame_start), e_fs);
    chk("in_text",     int'(bus.out_in_text),     e_it);
  endtask

  task automatic blank(input int top);
    cyc(0, 1, 0, 0, 0, top, fine_v);
    cyc(0, 1, 0, 0, 0, top, fine_v);
    cyc(0, 0, 0, 0, 0, top, fine_v);
    cyc(0, 0, 0, 0, 0, top, fine_v);
  endtask

  task automatic line(input int w, input int top, input bit vst);
    cyc(1, 0, 0, 1, vst, top, fine_v);
    for (int i = 1; i < w; i++) cyc(1, 0, 0, 0, 0, top, fine_v);
    blank(top);
  endtask

  initial begin
    // hand-derived vectors: unsynced line start, frame start at top 3, then lines
    tbl[0]  = '{1,0,0,1,0, 0, 0,0,1, 0,0,0,0,0};
    tbl[1]  = '{1,0,0,1,1, 3, 0,0,1, 3,0,1,1,1};
    tbl[2]  = '{1,0,0,0,0, 3, 0,1,0, 3,0,0,0,1};
    tbl[3]  = '{1,0,0,0,0, 3, 0,2,0, 3,0,0,0,1};
    tbl[4]  = '{1,0,0,0,0, 3, 0,3,0, 3,0,0,0,1};
    tbl[5]  = '{1,0,0,0,0, 3, 1,0,1, 3,0,0,0,1};
    tbl[6]  = '{0,1,0,0,0, 3, 0,0,0, 3,0,0,0,0};
    tbl[7]  = '{1,0,0,1,0, 3, 0,0,1, 3,1,0,0,1};
    tbl[8]  = '{0,0,1,1,0, 3, 0,0,0, 3,1,0,0,0};
    tbl[9]  = '{1,0,0,1,0, 3, 0,0,1, 3,2,0,0,1};
    tbl[10] = '{1,0,0,1,0, 3, 0,0,1, 4,0,1,0,1};
    tbl[11] = '{1,0,0,1,0, 7, 0,0,1, 4,1,0,0,1};

    reset = 1'b1;
    repeat (3) cyc(1, 1, 1, 1, 0, 5, 0);
    chk("rst_in_text", int'(bus.out_in_text), 0);
    chk("rst_active",  int'(bus.out_active), 0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].a, tbl[i].hs, tbl[i].vs, tbl[i].hst, tbl[i].vst, tbl[i].top, 0);
      chk($sformatf("tbl%0d.col", i),       int'(bus.out_col),         tbl[i].col);
      chk($sformatf("tbl%0d.cp", i),        int'(bus.out_col_pixel),   tbl[i].cp);
      chk($sformatf("tbl%0d.cs", i),        int'(bus.out_col_start),   tbl[i].cs);
      chk($sformatf("tbl%0d.row", i),       int'(bus.out_row),         tbl[i].row);
      chk($sformatf("tbl%0d.rp", i),        int'(bus.out_row_pixel),   tbl[i].rp);
      chk($sformatf("tbl%0d.rs", i),        int'(bus.out_row_start),   tbl[i].rs);
      chk($sformatf("tbl%0d.fs", i),        int'(bus.out_frame_start), tbl[i].fs);
      chk($sformatf("tbl%0d.it", i),        int'(bus.out_in_text),     tbl[i].it);
    end
    blank(0);

    // frame at top 0: cell boundary, right edge of window, second text row
    cyc(1, 0, 0, 1, 1, 0, 0);
    repeat (GW) cyc(1, 0, 0, 0, 0, 0, 0);
    chk("d_col1", int'(bus.out_col), 1);
    chk("d_cp0",  int'(bus.out_col_pixel), 0);
    chk("d_cs1",  int'(bus.out_col_start), 1);
    repeat (COLS * GW - 1 - GW) cyc(1, 0, 0, 0, 0, 0, 0);
    chk("d_edge_in", int'(bus.out_in_text), 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("d_edge_out", int'(bus.out_in_text), 0);
    repeat (W - 1 - COLS * GW) cyc(1, 0, 0, 0, 0, 0, 0);
    blank(0);
    repeat (GH - 1) line(W, 0, 0);
    cyc(1, 0, 0, 1, 0, 0, 0);
    chk("d_row1",  int'(bus.out_row), 1);
    chk("d_row1s", int'(bus.out_row_start), 1);
    repeat (W - 1) cyc(1, 0, 0, 0, 0, 0, 0);
    blank(0);

    // top 22: buffer row wraps to 0, then bottom edge of window
    line(W, 22, 1);
    for (int y = 1; y <= ROWS * GH; y++) begin
      cyc(1, 0, 0, 1, 0, 22, 0);
      if (y == 2 * GH) begin
        chk("d_wrap_row", int'(bus.out_row), 0);
        chk("d_wrap_rs",  int'(bus.out_row_start), 1);
      end
      if (y == ROWS * GH - 1) chk("d_bottom_in",  int'(bus.out_in_text), 1);
      if (y == ROWS * GH)     chk("d_bottom_out", int'(bus.out_in_text), 0);
      repeat (W - 1) cyc(1, 0, 0, 0, 0, 22, 0);
      blank(22);
    end

    // top_row changes mid-frame: no effect until next frame start
    line(W, 5, 1);
    repeat (2 * GH - 1) line(8, 9, 0);
    cyc(1, 0, 0, 1, 0, 9, 0);
    chk("d_notear", int'(bus.out_row), 7);
    blank(9);
    cyc(1, 0, 0, 1, 1, 9, 0);
    chk("d_newtop", int'(bus.out_row), 9);
    blank(9);

    // out-of-range top_row clamps to 0
    cyc(1, 0, 0, 1, 1, 30, 0);
    chk("d_clamp", int'(bus.out_row), 0);
    blank(0);

    // long line: column saturates
    cyc(1, 0, 0, 1, 0, 0, 0);
    repeat (79) cyc(1, 0, 0, 0, 0, 0, 0);
    chk("d_colsat", int'(bus.out_col), COL_SAT);
    blank(0);

    // reset mid-line: outputs drop, no text until next frame start
    cyc(1, 0, 0, 1, 1, 4, 0);
    repeat (5) cyc(1, 0, 0, 0, 0, 4, 0);
    reset = 1'b1;
    cyc(1, 0, 0, 0, 0, 4, 0);
    chk("d_mrst_col", int'(bus.out_col_pixel), 0);
    chk("d_mrst_row", int'(bus.out_row), 0);
    reset = 1'b0;
    cyc(1, 0, 0, 1, 0, 4, 0);
    chk("d_mrst_notext", int'(bus.out_in_text), 0);
    blank(4);

`ifdef HDMI_TEXT_FINE_SCROLL_EN
    // fine scroll: first row is partial, row_start suppressed at frame start
    fine_v = 2;
    cyc(1, 0, 0, 1, 1, 6, fine_v);
    chk("d_fine_rp", int'(bus.out_row_pixel), 2);
    chk("d_fine_rs", int'(bus.out_row_start), 0);
    blank(6);
    cyc(1, 0, 0, 1, 0, 6, fine_v);
    chk("d_fine_row", int'(bus.out_row), 7);
    chk("d_fine_rs1", int'(bus.out_row_start), 1);
    blank(6);
`endif

    // randomized frames: top_row/fine_row jitter every cycle, junk during blanking
    for (int fr = 0; fr < 5; fr++) begin
      int lines;
      lines  = $urandom_range(60, 78);
      fine_v = $urandom_range(0, 3);
      for (int y = 0; y < lines; y++) begin
        int w;
        w = $urandom_range(30, 70);
        cyc(1, 0, 0, 1, (y == 0), $urandom_range(0, 31), fine_v);
        for (int i = 1; i < w; i++)
          cyc(1, 0, 0, 0, ($urandom_range(0, 15) == 0), $urandom_range(0, 31), fine_v);
        for (int b = $urandom_range(1, 6); b > 0; b--)
          cyc(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 3));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
